lsu_mem_ctrl: RTL and testbench

LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

---
 rtl/lsu_mem_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller: one outstanding TCM command per accepted op.
// Optional ZCRV_LSU_RDATA_REG_EN registers formatted load data and adds a WB cycle.
module lsu_mem_ctrl #(
    parameter int ZCRV_ADDR_SIZE = 32,
    parameter int ZCRV_XLEN      = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ex_valid,
    input  logic                      load,
    input  logic                      store,
    input  logic                      itcm_req,
    input  logic                      dtcm_req,
    input  logic                      addr_error,
    input  logic [ZCRV_ADDR_SIZE-1:0] lsaddr,
    input  logic [ZCRV_XLEN-1:0]      store_result,
    input  logic [3:0]                store_mask,
    input  logic [4:0]                load_info,
    output logic                      lsu_ready,
    output logic                      mem_cmd_valid,
    input  logic                      mem_cmd_ready,
    output logic                      mem_cmd_itcm,
    output logic                      mem_cmd_wr,
    output logic [ZCRV_ADDR_SIZE-1:0] mem_cmd_addr,
    output logic [ZCRV_XLEN-1:0]      mem_cmd_wdata,
    output logic [3:0]                mem_cmd_be,
    input  logic                      mem_rsp_valid,
    input  logic [ZCRV_XLEN-1:0]      mem_rsp_rdata,
    output logic                      wb_valid,
    output logic                      wb_err,
    output logic                      store_done,
    output logic [ZCRV_XLEN-1:0]      wb_data,
    output logic [2:0]                dbg_state
);
    // Command handshake: a command transfers on a cycle where mem_cmd_valid and
    // mem_cmd_ready are both high; fields stay stable while valid waits for ready.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        RSP  = 3'd2,
`ifdef ZCRV_LSU_RDATA_REG_EN
        ERR  = 3'd3,
        WB   = 3'd4
`else
        ERR  = 3'd3
`endif
    } state_e;

    state_e                    state_q, state_d;
    logic                      itcm_q, itcm_d;
    logic                      wr_q, wr_d;
    logic [ZCRV_ADDR_SIZE-1:0] addr_q, addr_d;
    logic [ZCRV_XLEN-1:0]      wdata_q, wdata_d;
    logic [3:0]                be_q, be_d;
    logic [4:0]                linfo_q, linfo_d;
    logic [ZCRV_XLEN-1:0]      rsp_shifted;
    logic [ZCRV_XLEN-1:0]      rsp_fmt;
    logic [3:0]                store_be;
`ifdef ZCRV_LSU_RDATA_REG_EN
    logic [ZCRV_XLEN-1:0]      rdata_q, rdata_d;
`endif

    assign store_be      = (~store_mask) << lsaddr[1:0];
    assign mem_cmd_itcm  = itcm_q;
    assign mem_cmd_wr    = wr_q;
    assign mem_cmd_addr  = {addr_q[ZCRV_ADDR_SIZE-1:2], 2'b00};
    assign mem_cmd_wdata = wdata_q;
    assign mem_cmd_be    = be_q;
    assign dbg_state     = state_q;

    // Load data alignment and extension; info bits are {lb,lh,lw,lbu,lhu}.
    always_comb begin
        rsp_shifted = mem_rsp_rdata >> {addr_q[1:0], 3'b000};
        rsp_fmt     = rsp_shifted;
        if (linfo_q[2]) begin
            rsp_fmt = rsp_shifted;
        end else if (linfo_q[4]) begin
            rsp_fmt = {{(ZCRV_XLEN-8){rsp_shifted[7]}}, rsp_shifted[7:0]};
        end else if (linfo_q[3]) begin
            rsp_fmt = {{(ZCRV_XLEN-16){rsp_shifted[15]}}, rsp_shifted[15:0]};
        end else if (linfo_q[1]) begin
            rsp_fmt = {{(ZCRV_XLEN-8){1'b0}}, rsp_shifted[7:0]};
        end else if (linfo_q[0]) begin
            rsp_fmt = {{(ZCRV_XLEN-16){1'b0}}, rsp_shifted[15:0]};
        end
    end

    always_comb begin
        state_d       = state_q;
        itcm_d        = itcm_q;
        wr_d          = wr_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        be_d          = be_q;
        linfo_d       = linfo_q;
`ifdef ZCRV_LSU_RDATA_REG_EN
        rdata_d       = rdata_q;
`endif
        lsu_ready     = 1'b0;
        mem_cmd_valid = 1'b0;
        wb_valid      = 1'b0;
        wb_err        = 1'b0;
        store_done    = 1'b0;
        wb_data       = '0;
        case (state_q)
            IDLE: begin
                lsu_ready = 1'b1;
                if (ex_valid && (load || store || addr_error)) begin
                    // A conflicting TCM select falls back to DTCM.
                    itcm_d  = itcm_req & ~dtcm_req;
                    wr_d    = store;
                    addr_d  = lsaddr;
                    wdata_d = store ? (store_result << {lsaddr[1:0], 3'b000}) : '0;
                    be_d    = store ? store_be : 4'b1111;
                    linfo_d = load_info;
                    state_d = addr_error ? ERR : CMD;
                end
            end
            CMD: begin
                mem_cmd_valid = 1'b1;
                if (mem_cmd_ready) state_d = RSP;
            end
            RSP: begin
                if (mem_rsp_valid) begin
                    state_d = IDLE;
                    if (wr_q) begin
                        store_done = 1'b1;
                    end else begin
`ifdef ZCRV_LSU_RDATA_REG_EN
                        rdata_d = rsp_fmt;
                        state_d = WB;
`else
                        wb_valid = 1'b1;
                        wb_data  = rsp_fmt;
`endif
                    end
                end
            end
            ERR: begin
                wb_valid = 1'b1;
                wb_err   = 1'b1;
                state_d  = IDLE;
            end
`ifdef ZCRV_LSU_RDATA_REG_EN
            WB: begin
                wb_valid = 1'b1;
                wb_data  = rdata_q;
                state_d  = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            itcm_q  <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= 4'b0000;
            linfo_q <= 5'b00000;
`ifdef ZCRV_LSU_RDATA_REG_EN
            rdata_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            itcm_q  <= itcm_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            linfo_q <= linfo_d;
`ifdef ZCRV_LSU_RDATA_REG_EN
            rdata_q <= rdata_d;
`endif
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed scoreboard bench for lsu_mem_ctrl: driver pushes expected commands and
// writebacks, an independent monitor pops and compares them as the DUT presents them.
module tb_lsu_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0, load = 1'b0, store = 1'b0;
    logic        itcm_req = 1'b0, dtcm_req = 1'b0, addr_error = 1'b0;
    logic [31:0] lsaddr = '0, store_result = '0;
    logic [3:0]  store_mask = '0;
    logic [4:0]  load_info = '0;
    logic        lsu_ready, mem_cmd_valid, mem_cmd_ready = 1'b0;
    logic        mem_cmd_itcm, mem_cmd_wr;
    logic [31:0] mem_cmd_addr, mem_cmd_wdata;
    logic [3:0]  mem_cmd_be;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_rdata = '0;
    logic        wb_valid, wb_err, store_done;
    logic [31:0] wb_data;
    logic [2:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic [69:0] cmd_q[$];
    logic [35:0] wb_q[$];

`ifdef ZCRV_LSU_RDATA_REG_EN
    localparam logic LD_RSP = 1'b0;
`else
    localparam logic LD_RSP = 1'b1;
`endif

    lsu_mem_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .load(load), .store(store),
        .itcm_req(itcm_req), .dtcm_req(dtcm_req), .addr_error(addr_error),
        .lsaddr(lsaddr), .store_result(store_result), .store_mask(store_mask),
        .load_info(load_info), .lsu_ready(lsu_ready), .mem_cmd_valid(mem_cmd_valid),
        .mem_cmd_ready(mem_cmd_ready), .mem_cmd_itcm(mem_cmd_itcm), .mem_cmd_wr(mem_cmd_wr),
        .mem_cmd_addr(mem_cmd_addr), .mem_cmd_wdata(mem_cmd_wdata), .mem_cmd_be(mem_cmd_be),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .wb_valid(wb_valid),
        .wb_err(wb_err), .store_done(store_done), .wb_data(wb_data), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Monitor: cmd tuple {itcm,wr,addr,wdata,be}; wb tuple {wb_valid,wb_err,store_done,rsp_valid,wb_data}.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_cmd_valid && mem_cmd_ready) begin
                    if (cmd_q.size() == 0) check("cmd_unexpected", 72'd1, 72'd0);
                    else check("cmd", {2'b0, mem_cmd_itcm, mem_cmd_wr, mem_cmd_addr, mem_cmd_wdata, mem_cmd_be},
                               {2'b0, cmd_q.pop_front()});
                end
                if (wb_valid || store_done) begin
                    if (wb_q.size() == 0) check("wb_unexpected", 72'd1, 72'd0);
                    else check("wb", {36'b0, wb_valid, wb_err, store_done, mem_rsp_valid, wb_data},
                               {36'b0, wb_q.pop_front()});
                end
                if (!wb_valid) check("wb_data_idle", {40'b0, wb_data}, 72'd0);
            end
        end
    end

    task automatic wait_ready();
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = lsu_ready;
        end
        if (!seen) check("lsu_ready_timeout", 72'd0, 72'd1);
    endtask

    task automatic issue(input logic ld, input logic st, input logic itcm, input logic aerr,
                         input logic [31:0] addr, input logic [31:0] sres,
                         input logic [3:0] smask, input logic [4:0] linfo);
        wait_ready();
        @(posedge clk); #1;
        ex_valid = 1'b1; load = ld; store = st; itcm_req = itcm; dtcm_req = ~itcm;
        addr_error = aerr; lsaddr = addr; store_result = sres; store_mask = smask;
        load_info = linfo;
        @(posedge clk); #1;
        ex_valid = 1'b0; load = 1'b0; store = 1'b0; addr_error = 1'b0;
        lsaddr = 32'h5A5A_5A5A; store_result = 32'hC3C3_C3C3;
    endtask

    // Holds ready low for 'stall' cycles, checking the command stays stable, then hands it off.
    task automatic run_cmd(input int stall, input logic [69:0] exp_cmd);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("cmd_hold", {1'b0, mem_cmd_valid, mem_cmd_itcm, mem_cmd_wr, mem_cmd_addr,
                  mem_cmd_wdata, mem_cmd_be}, {1'b0, 1'b1, exp_cmd});
            @(posedge clk); #1;
        end
        mem_cmd_ready = 1'b1;
        @(negedge clk);
        check("cmd_hold", {1'b0, mem_cmd_valid, mem_cmd_itcm, mem_cmd_wr, mem_cmd_addr,
              mem_cmd_wdata, mem_cmd_be}, {1'b0, 1'b1, exp_cmd});
        @(posedge clk); #1;
        mem_cmd_ready = 1'b0;
    endtask

    task automatic do_op(input logic ld, input logic st, input logic itcm,
                         input logic [31:0] addr, input logic [31:0] sres,
                         input logic [3:0] smask, input logic [4:0] linfo,
                         input logic [31:0] rdata, input int stall,
                         input logic [69:0] exp_cmd, input logic [35:0] exp_wb);
        cmd_q.push_back(exp_cmd);
        wb_q.push_back(exp_wb);
        issue(ld, st, itcm, 1'b0, addr, sres, smask, linfo);
        run_cmd(stall, exp_cmd);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = rdata;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 32'hDEAD_0000;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_state", {26'b0, lsu_ready, mem_cmd_valid, wb_valid, wb_err, store_done,
              mem_cmd_itcm, mem_cmd_wr, mem_cmd_be, mem_cmd_addr, wb_data},
              {26'b0, 1'b1, 6'b0, 4'b0, 64'b0});
        check("reset_wdata", {40'b0, mem_cmd_wdata}, 72'd0);

        // lw / lb / lbu / lh / lhu and an ITCM lbu at offset 0
        do_op(1, 0, 0, 32'h0000_0100, 0, 4'b0, 5'b00100, 32'h8899_AABB, 0,
              {2'b00, 32'h0000_0100, 32'h0, 4'hF}, {3'b100, LD_RSP, 32'h8899_AABB});
        do_op(1, 0, 0, 32'h0000_0103, 0, 4'b0, 5'b10000, 32'h80FF_0000, 0,
              {2'b00, 32'h0000_0100, 32'h0, 4'hF}, {3'b100, LD_RSP, 32'hFFFF_FF80});
        do_op(1, 0, 0, 32'h0000_0103, 0, 4'b0, 5'b00010, 32'h80FF_0000, 0,
              {2'b00, 32'h0000_0100, 32'h0, 4'hF}, {3'b100, LD_RSP, 32'h0000_0080});
        do_op(1, 0, 0, 32'h0000_0202, 0, 4'b0, 5'b01000, 32'h8001_1234, 1,
              {2'b00, 32'h0000_0200, 32'h0, 4'hF}, {3'b100, LD_RSP, 32'hFFFF_8001});
        do_op(1, 0, 0, 32'h0000_0202, 0, 4'b0, 5'b00001, 32'h8001_1234, 0,
              {2'b00, 32'h0000_0200, 32'h0, 4'hF}, {3'b100, LD_RSP, 32'h0000_8001});
        do_op(1, 0, 1, 32'h8000_0000, 0, 4'b0, 5'b00010, 32'h1234_56F0, 0,
              {2'b10, 32'h8000_0000, 32'h0, 4'hF}, {3'b100, LD_RSP, 32'h0000_00F0});

        // sh to ITCM, sb to DTCM, and load+store together treated as sw
        do_op(0, 1, 1, 32'h8000_0002, 32'h0000_BEEF, 4'b1100, 5'b0, 32'hDEAD_BEEF, 1,
              {2'b11, 32'h8000_0000, 32'hBEEF_0000, 4'b1100}, {3'b001, 1'b1, 32'h0});
        do_op(0, 1, 0, 32'h0000_0101, 32'h0000_00A5, 4'b1110, 5'b0, 32'h0, 0,
              {2'b01, 32'h0000_0100, 32'h0000_A500, 4'b0010}, {3'b001, 1'b1, 32'h0});
        do_op(1, 1, 0, 32'h0000_0010, 32'h1234_5678, 4'b0000, 5'b00100, 32'hFFFF_FFFF, 0,
              {2'b01, 32'h0000_0010, 32'h1234_5678, 4'b1111}, {3'b001, 1'b1, 32'h0});

        // Misaligned access: error writeback, no command, ready again the cycle after
        wb_q.push_back({3'b110, 1'b0, 32'h0});
        issue(1, 0, 0, 1'b1, 32'h0000_0301, 0, 4'b0, 5'b00100);
        @(negedge clk);
        check("err_no_cmd", {71'b0, mem_cmd_valid}, 72'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("err_ready_after", {71'b0, lsu_ready}, 72'd1);

        // Stalled command, then reset while awaiting the response
        cmd_q.push_back({2'b00, 32'h0000_0040, 32'h0, 4'hF});
        issue(1, 0, 0, 1'b0, 32'h0000_0040, 0, 4'b0, 5'b00100);
        run_cmd(3, {2'b00, 32'h0000_0040, 32'h0, 4'hF});
        rst_n = 1'b0;
        #1;
        check("rst_in_rsp", {66'b0, lsu_ready, mem_cmd_valid, wb_valid, wb_err, store_done,
              mem_cmd_wr}, {66'b0, 6'b100000});
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h1111_2222;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("no_wb_after_rst", {68'b0, wb_valid, store_done, mem_cmd_valid, lsu_ready},
              {68'b0, 4'b0001});
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;

        // Same lw after reset recovery
        do_op(1, 0, 0, 32'h0000_0100, 0, 4'b0, 5'b00100, 32'h8899_AABB, 0,
              {2'b00, 32'h0000_0100, 32'h0, 4'hF}, {3'b100, LD_RSP, 32'h8899_AABB});

        repeat (4) @(negedge clk);
        check("cmd_q_drained", {40'b0, cmd_q.size()}, 72'd0);
        check("wb_q_drained", {40'b0, wb_q.size()}, 72'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
